// File: rtl/prbs31_pkg.sv
// Shared constants and FSM encoding for the PRBS31 (x^31 + x^28 + 1) burst sequencer.
package prbs31_pkg;

  localparam int unsigned LFSR_W     = 31;
  localparam int unsigned TAP_A      = 31;
  localparam int unsigned TAP_B      = 28;
  localparam int unsigned SYNC_LEN   = 31;
  localparam int unsigned SYNC_CNT_W = 5;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SYNC,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/prbs31_lfsr.sv
// 31-bit Fibonacci LFSR: loadable, shifts either its own feedback (generator)
// or an external bit (self-synchronising checker). fb_c is the next/predicted bit.
module prbs31_lfsr
  import prbs31_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              shift,
  input  logic              ext_sel,
  input  logic              ext_bit,
  output logic              fb_c
);

  logic [LFSR_W-1:0] s_q;

  assign fb_c = s_q[TAP_A-1] ^ s_q[TAP_B-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= RST_VAL;
    end else if (ena) begin
      if (load) begin
        s_q <= load_val;
      end else if (shift) begin
        s_q <= {s_q[LFSR_W-2:0], (ext_sel ? ext_bit : fb_c)};
      end
    end
  end

endmodule

// File: rtl/prbs31_burst_ctrl.sv
// PRBS31 burst sequencer: seeds the TX generator, synchronises the checker on the
// looped-back stream for 31 cycles, then counts compared bits and errors.
module prbs31_burst_ctrl
  import prbs31_pkg::*;
#(
  parameter int unsigned       LEN_W = 16,
  parameter int unsigned       ERR_W = 8,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             inject_err,
  input  logic             rx_bit,
  output logic             tx_bit,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [LEN_W-1:0] bit_cnt
);

  state_e                  state_q, state_nxt;
  logic [LEN_W-1:0]        len_q, len_nxt;
  logic [LEN_W-1:0]        bit_nxt;
  logic [ERR_W-1:0]        err_nxt;
  logic [SYNC_CNT_W-1:0]   sync_q, sync_nxt;
  logic                    tx_load, chk_load, shift_en;
  logic                    tx_fb_c, chk_fb_c;
  logic                    active_c;

  prbs31_lfsr #(.RST_VAL(SEED)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (tx_load),
    .load_val (SEED),
    .shift    (shift_en),
    .ext_sel  (1'b0),
    .ext_bit  (1'b0),
    .fb_c     (tx_fb_c)
  );

  prbs31_lfsr #(.RST_VAL('0)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (chk_load),
    .load_val ('0),
    .shift    (shift_en),
    .ext_sel  (1'b1),
    .ext_bit  (rx_bit),
    .fb_c     (chk_fb_c)
  );

  // Transmit path is combinational so injected errors land in the same cycle.
  assign active_c = (state_q == ST_SYNC) || (state_q == ST_RUN);
  assign tx_bit   = active_c ? (tx_fb_c ^ inject_err) : 1'b0;

  always_comb begin
    state_nxt = state_q;
    len_nxt   = len_q;
    bit_nxt   = bit_cnt;
    err_nxt   = err_cnt;
    sync_nxt  = sync_q;
    tx_load   = 1'b0;
    chk_load  = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SEED;
          len_nxt   = burst_len;
          bit_nxt   = '0;
          err_nxt   = '0;
          chk_load  = 1'b1;
        end
      end
      ST_SEED: begin
        tx_load   = 1'b1;
        sync_nxt  = '0;
        state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        shift_en = 1'b1;
        sync_nxt = sync_q + SYNC_CNT_W'(1);
        if (sync_q == SYNC_CNT_W'(SYNC_LEN - 1)) begin
          state_nxt = (len_q == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        shift_en = 1'b1;
        bit_nxt  = bit_cnt + LEN_W'(1);
        if ((rx_bit != chk_fb_c) && (err_cnt != '1)) begin
          err_nxt = err_cnt + ERR_W'(1);
        end
        if (bit_nxt == len_q) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next-state so they align with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      bit_cnt <= '0;
      err_cnt <= '0;
      sync_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else if (ena) begin
      state_q <= state_nxt;
      len_q   <= len_nxt;
      bit_cnt <= bit_nxt;
      err_cnt <= err_nxt;
      sync_q  <= sync_nxt;
      busy    <= (state_nxt == ST_SEED) || (state_nxt == ST_SYNC) || (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
      pass    <= (state_nxt == ST_DONE) && (err_nxt == '0);
    end
  end

endmodule
